// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide engine for the EXE stage.
// Produces {HI,LO} for MULT/MULTU/DIV/DIVU with a one-cycle finish strobe;
// busy_o stalls the pipeline while an operation is in flight.
module mult_div_unit #(
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [1:0]        op_i,
   input  logic [DATA_W-1:0] src_a_i,
   input  logic [DATA_W-1:0] src_b_i,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              finish_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   localparam int PW      = 2 * DATA_W;
   localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              accept, mul_last, div_last;

   // multiplier signals
   logic signed [DATA_W:0] mul_a, mul_b;
   logic [PW-1:0]          mul_full;
   logic [MUL_LAT*PW-1:0]  prod_q;
   logic [PW-1:0]          prod_out;

   // divider signals
   logic              div_signed;
   logic [DATA_W-1:0] a_mag, b_mag;
   logic [DATA_W-1:0] quo_q, rem_q, den_q;
   logic              neg_quo_q, neg_rem_q;
   logic [DATA_W:0]   rem_sh;
   logic [DATA_W-1:0] rem_diff;
   logic              rem_ge;
   logic [DATA_W-1:0] quo_nx, rem_nx, quo_fin, rem_fin;

   assign accept   = start_i & ~flush_i & (state_q == IDLE);
   assign mul_last = (state_q == MUL) & (cnt_q == MUL_LAST);
   assign div_last = (state_q == DIV) & (cnt_q == DIV_LAST);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next-state logic, stall request and finish strobe
   always_comb begin
      state_d  = state_q;
      busy_o   = 1'b0;
      finish_o = 1'b0;
      case (state_q)
         IDLE: begin
            busy_o = accept;
            if (accept) state_d = op_i[1] ? DIV : MUL;
         end
         MUL: begin
            busy_o = 1'b1;
            if (flush_i)       state_d = IDLE;
            else if (mul_last) state_d = DONE;
         end
         DIV: begin
            busy_o = 1'b1;
            if (flush_i)       state_d = IDLE;
            else if (div_last) state_d = DONE;
         end
         DONE: begin
            finish_o = ~flush_i;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // iteration counter, cleared whenever the FSM leaves or is outside MUL/DIV
   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if ((state_q == MUL || state_q == DIV) && state_d == state_q)
         cnt_q <= cnt_q + 1'b1;
      else
         cnt_q <= '0;
   end

   // product of the live inputs; the chain below carries the accepting-cycle
   // value forward so later input changes cannot reach the result
   always_comb begin
      mul_a    = {~op_i[0] & src_a_i[DATA_W-1], src_a_i};
      mul_b    = {~op_i[0] & src_b_i[DATA_W-1], src_b_i};
      mul_full = PW'(mul_a) * PW'(mul_b);
   end

   if (MUL_LAT == 1) begin : g_chain1
      // single product register
      always_ff @(posedge clk) begin
         if (rst) prod_q <= '0;
         else     prod_q <= mul_full;
      end
   end else begin : g_chain_n
      // free-running product shift chain, MUL_LAT stages deep
      always_ff @(posedge clk) begin
         if (rst) prod_q <= '0;
         else     prod_q <= {prod_q[(MUL_LAT-1)*PW-1:0], mul_full};
      end
   end

   assign prod_out = prod_q[MUL_LAT*PW-1 -: PW];

   // operand magnitudes and one restoring-division step
   always_comb begin
      div_signed = ~op_i[0];
      a_mag      = (div_signed & src_a_i[DATA_W-1]) ? -src_a_i : src_a_i;
      b_mag      = (div_signed & src_b_i[DATA_W-1]) ? -src_b_i : src_b_i;
      rem_sh     = {rem_q, quo_q[DATA_W-1]};
      rem_ge     = rem_sh >= {1'b0, den_q};
      rem_diff   = rem_sh[DATA_W-1:0] - den_q;
      rem_nx     = rem_ge ? rem_diff : rem_sh[DATA_W-1:0];
      quo_nx     = {quo_q[DATA_W-2:0], rem_ge};
      quo_fin    = neg_quo_q ? -quo_nx : quo_nx;
      rem_fin    = neg_rem_q ? -rem_nx : rem_nx;
   end

   // divider state and HI/LO result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         quo_q     <= '0;
         rem_q     <= '0;
         den_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_o      <= '0;
         lo_o      <= '0;
      end else begin
         if (accept) begin
            quo_q     <= a_mag;
            rem_q     <= '0;
            den_q     <= b_mag;
            neg_quo_q <= div_signed & (src_a_i[DATA_W-1] ^ src_b_i[DATA_W-1]);
            neg_rem_q <= div_signed & src_a_i[DATA_W-1];
         end else if (state_q == DIV) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
         end
         if (mul_last & ~flush_i) begin
            hi_o <= prod_out[PW-1:DATA_W];
            lo_o <= prod_out[DATA_W-1:0];
         end else if (div_last & ~flush_i) begin
            hi_o <= rem_fin;
            lo_o <= quo_fin;
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed ops with a result scoreboard.
module tb_mult_div_unit;

   localparam int W  = 32;
   localparam int ML = 2;

   logic         clk = 1'b0;
   logic         rst, start_i, flush_i;
   logic [1:0]   op_i;
   logic [W-1:0] src_a_i, src_b_i;
   logic         busy_o, finish_o;
   logic [W-1:0] hi_o, lo_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int fin_count = 0;
   int fin_cyc   = -1;
   logic [63:0] exp_q[$];
   logic [63:0] last_res;

   mult_div_unit #(.DATA_W(W), .MUL_LAT(ML)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
      .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
      .busy_o(busy_o), .finish_o(finish_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   // reference model: {hi,lo}
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [65:0] p;
      logic [31:0] q, r;
      q = '0; r = '0; p = '0;
      case (op)
         2'd0: begin p = $signed({a[31], a}) * $signed({b[31], b}); return p[63:0]; end
         2'd1: begin p = $signed({1'b0, a}) * $signed({1'b0, b}); return p[63:0]; end
         2'd2: begin
            if (b == 0) begin q = a[31] ? 32'd1 : 32'hFFFF_FFFF; r = a; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = 0; end
            else begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
         end
         default: begin
            if (b == 0) begin q = 32'hFFFF_FFFF; r = a; end
            else begin q = a / b; r = a % b; end
         end
      endcase
      return {r, q};
   endfunction

   // scoreboard: pop and compare on every finish strobe
   always @(negedge clk) begin
      if (!rst && finish_o) begin
         fin_count <= fin_count + 1;
         fin_cyc   <= cyc;
         check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) check("result", {hi_o, lo_o}, exp_q.pop_front());
      end
   end

   // issue one op at posedge+1 and wait (bounded) for its finish strobe
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
      int n0, c0, lat;
      lat = op[1] ? W : ML;
      n0 = fin_count;
      c0 = cyc;
      op_i = op; src_a_i = a; src_b_i = b; start_i = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      start_i = 1'b0; op_i = ~op; src_a_i = $urandom; src_b_i = $urandom;
      for (int i = 0; i < lat + 6; i++) begin
         @(posedge clk);
         if (fin_count != n0) break;
      end
      #1;
      check({tag, "_done"}, 64'(fin_count - n0), 64'd1);
      check({tag, "_lat"}, 64'(fin_cyc - c0), 64'(lat + 1));
      last_res = exp;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, c0;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; src_a_i = '0; src_b_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy",   64'(busy_o), 64'd0);
      check("rst_finish", 64'(finish_o), 64'd0);
      check("rst_hilo",   {hi_o, lo_o}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // DIVU 100/7: busy trace and single finish strobe
      op_i = 2'b11; src_a_i = 32'd100; src_b_i = 32'd7; start_i = 1'b1;
      exp_q.push_back({32'd2, 32'd14});
      for (int k = 0; k <= 34; k++) begin
         @(negedge clk);
         check($sformatf("t1_busy_c%0d", k), 64'(busy_o), 64'(k <= 32));
         check($sformatf("t1_fin_c%0d", k), 64'(finish_o), 64'(k == 33));
         @(posedge clk); #1;
         if (k == 0) begin start_i = 1'b0; src_a_i = 32'hDEAD_BEEF; src_b_i = 32'd3; op_i = 2'b00; end
      end
      check("t1_hold", {hi_o, lo_o}, {32'd2, 32'd14});
      last_res = {32'd2, 32'd14};

      // signed divide, multiply, corner cases (back-to-back)
      run_op("div_m7_2",  2'b10, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op("div_7_m2",  2'b10, 32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
      run_op("mult",      2'b00, 32'hFFFF_FFFF, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFE});
      run_op("multu",     2'b01, 32'hFFFF_FFFF, 32'd2,         {32'd1, 32'hFFFF_FFFE});
      run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
      run_op("divu_z",    2'b11, 32'h1234,      32'd0,         {32'h1234, 32'hFFFF_FFFF});
      run_op("div_z_neg", 2'b10, 32'hFFFF_FFFB, 32'd0,         {32'hFFFF_FFFB, 32'd1});
      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom_range(0, 3)); ra = $urandom; rb = $urandom;
         if (i == 3) rb = rb >> 20;
         run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb));
      end

      // flush in cycle 10 of a DIVU
      n0 = fin_count;
      op_i = 2'b11; src_a_i = 32'd999; src_b_i = 32'd5; start_i = 1'b1;
      @(posedge clk); #1; start_i = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      flush_i = 1'b1;
      @(posedge clk); #1; flush_i = 1'b0;
      @(negedge clk);
      check("flush_busy", 64'(busy_o), 64'd0);
      check("flush_fin",  64'(finish_o), 64'd0);
      check("flush_hilo", {hi_o, lo_o}, last_res);
      repeat (40) @(posedge clk);
      check("flush_nofin", 64'(fin_count - n0), 64'd0);
      check("flush_hold",  {hi_o, lo_o}, last_res);
      #1;

      // rst in cycle 10 of a DIVU
      n0 = fin_count;
      op_i = 2'b11; src_a_i = 32'd999; src_b_i = 32'd5; start_i = 1'b1;
      @(posedge clk); #1; start_i = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("rstmid_busy", 64'(busy_o), 64'd0);
      check("rstmid_fin",  64'(finish_o), 64'd0);
      check("rstmid_hilo", {hi_o, lo_o}, 64'd0);
      repeat (40) @(posedge clk);
      check("rstmid_nofin", 64'(fin_count - n0), 64'd0);
      #1;
      last_res = '0;

      // start together with flush in IDLE is rejected
      n0 = fin_count;
      op_i = 2'b10; src_a_i = 32'd50; src_b_i = 32'd3; start_i = 1'b1; flush_i = 1'b1;
      @(negedge clk);
      check("sflush_busy0", 64'(busy_o), 64'd0);
      @(posedge clk); #1; start_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      check("sflush_busy1", 64'(busy_o), 64'd0);
      repeat (40) @(posedge clk);
      check("sflush_nofin", 64'(fin_count - n0), 64'd0);
      check("sflush_hilo",  {hi_o, lo_o}, 64'd0);
      #1;

      // MULT in flight with further start pulses (MUL and DONE cycles) ignored
      n0 = fin_count; c0 = cyc;
      op_i = 2'b00; src_a_i = 32'hFFFF_FFFF; src_b_i = 32'd2; start_i = 1'b1;
      exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFE});
      @(posedge clk); #1;
      op_i = 2'b11; src_a_i = 32'd7; src_b_i = 32'd9;
      @(negedge clk);
      check("ign_busy_mul", 64'(busy_o), 64'd1);
      repeat (ML) begin @(posedge clk); #1; end
      @(negedge clk);
      check("ign_busy_done", 64'(busy_o), 64'd0);
      check("ign_fin_done",  64'(finish_o), 64'd1);
      @(posedge clk); #1; start_i = 1'b0;
      repeat (40) @(posedge clk);
      check("ign_one_fin", 64'(fin_count - n0), 64'd1);
      check("ign_lat",     64'(fin_cyc - c0), 64'(ML + 1));
      check("ign_hold",    {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
      #1;

      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
